// File: rtl/ifetch_seq.sv
// Instruction-fetch sequencer: owns the PC, reads one or two words from instruction
// memory and loads them into the IR, then pulses fetch_done to the control unit.
module ifetch_seq #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [15:0] LONG_OP_MASK = 16'h00F0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic        pc_load,
    input  logic [15:0] pc_in,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    output logic        ir_ld,
    output logic        ir_t,
    output logic [15:0] ir_in,
    output logic [15:0] pc,
    output logic        busy,
    output logic        fetch_done
);

    typedef enum logic [2:0] {IDLE, REQ1, LD1, REQ2, LD2, DONE} state_t;

    state_t     state;
    logic [3:0] opcode;

    // The read address is always the PC; it only matters while mem_rd is high.
    assign mem_addr = pc;

    // Every output flag is set on the transition into the state that owns it,
    // so all outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            ir_in      <= '0;
            opcode     <= '0;
            mem_rd     <= 1'b0;
            ir_ld      <= 1'b0;
            ir_t       <= 1'b0;
            busy       <= 1'b0;
            fetch_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pc_load) begin
                        pc <= pc_in;
                    end
                    if (fetch_req) begin
                        state  <= REQ1;
                        mem_rd <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                REQ1: begin
                    if (mem_ready) begin
                        ir_in  <= mem_rdata;
                        opcode <= mem_rdata[15:12];
                        state  <= LD1;
                        mem_rd <= 1'b0;
                        ir_ld  <= 1'b1;
                        ir_t   <= 1'b0;
                    end
                end
                LD1: begin
                    pc    <= pc + 16'd1;
                    ir_ld <= 1'b0;
                    if (LONG_OP_MASK[opcode]) begin
                        state  <= REQ2;
                        mem_rd <= 1'b1;
                    end else begin
                        state      <= DONE;
                        fetch_done <= 1'b1;
                    end
                end
                REQ2: begin
                    if (mem_ready) begin
                        ir_in  <= mem_rdata;
                        state  <= LD2;
                        mem_rd <= 1'b0;
                        ir_ld  <= 1'b1;
                        ir_t   <= 1'b1;
                    end
                end
                LD2: begin
                    pc         <= pc + 16'd1;
                    ir_ld      <= 1'b0;
                    ir_t       <= 1'b0;
                    state      <= DONE;
                    fetch_done <= 1'b1;
                end
                DONE: begin
                    fetch_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    mem_rd     <= 1'b0;
                    ir_ld      <= 1'b0;
                    ir_t       <= 1'b0;
                    busy       <= 1'b0;
                    fetch_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_seq.sv
// Scoreboard bench for ifetch_seq: a memory model feeds the DUT, predicted IR loads,
// read addresses and completions are queued and checked by an independent monitor.
module tb_ifetch_seq;

    localparam logic [15:0] RESET_PC     = 16'h0000;
    localparam logic [15:0] LONG_OP_MASK = 16'h00F0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_in = 16'h0000;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ready = 1'b0;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        ir_ld;
    logic        ir_t;
    logic [15:0] ir_in;
    logic [15:0] pc;
    logic        busy;
    logic        fetch_done;

    ifetch_seq #(.RESET_PC(RESET_PC), .LONG_OP_MASK(LONG_OP_MASK)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc_load(pc_load),
        .pc_in(pc_in), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .ir_ld(ir_ld), .ir_t(ir_t),
        .ir_in(ir_in), .pc(pc), .busy(busy), .fetch_done(fetch_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_done;
        logic        t;
        logic [15:0] w;
    } ev_t;

    ev_t         evq[$];
    logic [15:0] addrq[$];
    logic [15:0] mem [0:65535];
    logic [15:0] ref_pc;
    int          n_cmp = 0;
    int          n_err = 0;
    int          wait_cfg = 0;
    logic        rand_mode = 1'b0;
    logic        hold_low = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void flag(input string name);
        n_cmp++;
        n_err++;
        $display("[TB] FAIL %s: got an event, expected none", name);
    endfunction

    // Reference model: what a fetch from a given start address must produce.
    function automatic void predict(input logic ld, input logic [15:0] tgt);
        logic [15:0] a;
        logic [15:0] w1;
        a  = ld ? tgt : ref_pc;
        w1 = mem[a];
        addrq.push_back(a);
        evq.push_back('{is_done: 1'b0, t: 1'b0, w: w1});
        a = a + 16'd1;
        if (LONG_OP_MASK[w1[15:12]]) begin
            addrq.push_back(a);
            evq.push_back('{is_done: 1'b0, t: 1'b1, w: mem[a]});
            a = a + 16'd1;
        end
        evq.push_back('{is_done: 1'b1, t: 1'b0, w: a});
        ref_pc = a;
    endfunction

    // Memory responder: wait_cfg stall cycles per read, random readiness, or held off.
    int rd_run = 0;
    always @(posedge clk) begin
        #1;
        if (mem_rd) rd_run++;
        else rd_run = 0;
        mem_rdata = mem[mem_addr];
        if (hold_low) mem_ready = 1'b0;
        else if (rand_mode) mem_ready = ($urandom_range(0, 1) == 1);
        else mem_ready = !(mem_rd && (rd_run <= wait_cfg));
    end

    logic        prev_rd = 1'b0;
    logic        prev_ready = 1'b0;
    logic [15:0] prev_addr = 16'h0000;
    always @(posedge clk) begin
        ev_t e;
        #2;
        if (rst_n && prev_rd && !prev_ready) begin
            check("read held", 32'(mem_rd), 32'd1);
            check("addr stable", 32'(mem_addr), 32'(prev_addr));
        end
        if (mem_rd && mem_ready && rst_n) begin
            if (addrq.size() == 0) flag("unexpected read");
            else check("read addr", 32'(mem_addr), 32'(addrq.pop_front()));
        end
        if (!ir_ld) check("ir_t idle", 32'(ir_t), 32'd0);
        if (ir_ld) begin
            if (evq.size() == 0) flag("unexpected ir_ld");
            else begin
                e = evq.pop_front();
                check("ir_ld order", 32'(e.is_done), 32'd0);
                check("ir_t", 32'(ir_t), 32'(e.t));
                check("ir_in", 32'(ir_in), 32'(e.w));
            end
        end
        if (fetch_done) begin
            if (evq.size() == 0) flag("unexpected fetch_done");
            else begin
                e = evq.pop_front();
                check("done order", 32'(e.is_done), 32'd1);
                check("done pc", 32'(pc), 32'(e.w));
            end
        end
        prev_rd    = mem_rd;
        prev_ready = mem_ready;
        prev_addr  = mem_addr;
    end

    task automatic applyStimulus(input logic ld, input logic [15:0] tgt, input logic junk, output int cyc);
        logic done;
        @(negedge clk);
        fetch_req = 1'b1;
        pc_load   = ld;
        pc_in     = tgt;
        predict(ld, tgt);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (junk) begin
                fetch_req = ($urandom_range(0, 1) == 1);
                pc_load   = ($urandom_range(0, 1) == 1);
                pc_in     = 16'($urandom);
            end else begin
                fetch_req = 1'b0;
                pc_load   = 1'b0;
            end
            if (fetch_done) done = 1'b1;
        end
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        check("fetch completes", 32'(done), 32'd1);
    endtask

    task automatic checkOutput(input string name);
        check({name, " busy"}, 32'(busy), 32'd0);
        check({name, " pc"}, 32'(pc), 32'(ref_pc));
        check({name, " mem_rd"}, 32'(mem_rd), 32'd0);
        check({name, " ir_ld"}, 32'(ir_ld), 32'd0);
        check({name, " fetch_done"}, 32'(fetch_done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[16'h0000] = 16'h1234;
        mem[16'h0001] = 16'h4A50;
        mem[16'h0002] = 16'hBEEF;
        mem[16'h0003] = 16'h2222;
        mem[16'h0100] = 16'h3000;
        mem[16'h0101] = 16'h0ABC;
        mem[16'h0200] = 16'h7001;
        mem[16'hFFFF] = 16'h6123;
        ref_pc = RESET_PC;

        repeat (2) @(negedge clk);
        checkOutput("reset");
        check("reset ir_t", 32'(ir_t), 32'd0);
        check("reset ir_in", 32'(ir_in), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 16'h0000, 1'b0, cyc);
        check("latency one-word", 32'(cyc), 32'd3);
        applyStimulus(1'b0, 16'h0000, 1'b0, cyc);
        check("latency two-word", 32'(cyc), 32'd5);

        // Three stall cycles on the first read of a one-word instruction.
        wait_cfg = 3;
        applyStimulus(1'b0, 16'h0000, 1'b0, cyc);
        check("latency wait", 32'(cyc), 32'd6);
        wait_cfg = 0;

        applyStimulus(1'b1, 16'h0100, 1'b0, cyc);
        applyStimulus(1'b0, 16'h0000, 1'b1, cyc);
        repeat (3) @(negedge clk);
        checkOutput("ignore");

        applyStimulus(1'b1, 16'hFFFF, 1'b0, cyc);
        check("latency wrap", 32'(cyc), 32'd5);
        @(negedge clk);
        check("wrap pc", 32'(pc), 32'h0001);

        // Abort: stall the immediate read, then reset while sitting in REQ2.
        @(negedge clk);
        fetch_req = 1'b1;
        pc_load   = 1'b1;
        pc_in     = 16'h0200;
        predict(1'b1, 16'h0200);
        @(negedge clk);
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        @(negedge clk);
        hold_low = 1'b1;
        @(negedge clk);
        check("abort in REQ2 rd", 32'(mem_rd), 32'd1);
        check("abort in REQ2 addr", 32'(mem_addr), 32'h0201);
        rst_n = 1'b0;
        @(negedge clk);
        ref_pc = RESET_PC;
        checkOutput("abort");
        rst_n    = 1'b1;
        hold_low = 1'b0;
        evq.delete();
        addrq.delete();
        repeat (2) @(negedge clk);
        checkOutput("after abort");

        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                pc_load = 1'b1;
                pc_in   = 16'($urandom);
                ref_pc  = pc_in;
                @(negedge clk);
                pc_load = 1'b0;
                check("pc_load", 32'(pc), 32'(ref_pc));
            end else begin
                applyStimulus($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 1) == 1, cyc);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checkOutput("final");
        check("events drained", 32'(evq.size()), 32'd0);
        check("reads drained", 32'(addrq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
